// File: rtl/rvfi_trace_fifo.sv
// RVFI retirement trace FIFO: buffers picorv32 retirement records without ever stalling the core,
// tagging each with its retirement order and flagging gaps left by dropped records.
module rvfi_trace_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ORDER_W = 32,
    parameter int unsigned DROP_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [4:0]                 in_rd,
    input  logic [31:0]                in_insn,
    input  logic [31:0]                in_pre_pc,
    input  logic [31:0]                in_pre_rs1,
    input  logic [31:0]                in_pre_rs2,
    input  logic [31:0]                in_post_pc,
    input  logic [31:0]                in_post_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ORDER_W-1:0]         out_order,
    output logic                       out_gap,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_insn,
    output logic [31:0]                out_pre_pc,
    output logic [31:0]                out_pre_rs1,
    output logic [31:0]                out_pre_rs2,
    output logic [31:0]                out_post_pc,
    output logic [31:0]                out_post_rd,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic               gap;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [31:0]        insn;
        logic [31:0]        pre_pc;
        logic [31:0]        pre_rs1;
        logic [31:0]        pre_rs2;
        logic [31:0]        post_pc;
        logic [31:0]        post_rd;
    } rec_t;

    rec_t               mem_q [DEPTH];
    rec_t               wr_rec_s;
    rec_t               head_s;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               gap_pending_q, gap_pending_d;
    logic               overflow_q, overflow_d;

    logic               out_valid_s;
    logic               full_s;
    logic               pop_s;
    logic               push_ok_s;
    logic               drop_s;

    // Handshake decode and next-state computation for pointers, level and trace bookkeeping.
    always_comb begin
        out_valid_s   = (level_q != {LVL_W{1'b0}});
        full_s        = (level_q == LVL_W'(DEPTH));
        pop_s         = out_valid_s && out_ready;
        push_ok_s     = in_valid && (!full_s || pop_s);
        drop_s        = in_valid && !push_ok_s;

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        order_d       = order_q;
        drop_d        = drop_q;
        gap_pending_d = gap_pending_q;
        overflow_d    = overflow_q | drop_s;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Every retirement consumes an order number, including the ones that get dropped.
        if (in_valid) begin
            order_d = order_q + ORDER_W'(1);
        end else begin
            order_d = order_q;
        end

        if (drop_s && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end else begin
            drop_d = drop_q;
        end

        if (drop_s) begin
            gap_pending_d = 1'b1;
        end else if (push_ok_s) begin
            gap_pending_d = 1'b0;
        end else begin
            gap_pending_d = gap_pending_q;
        end

        wr_rec_s = '{order:   order_q,
                     gap:     gap_pending_q,
                     rs1:     in_rs1,
                     rs2:     in_rs2,
                     rd:      in_rd,
                     insn:    in_insn,
                     pre_pc:  in_pre_pc,
                     pre_rs1: in_pre_rs1,
                     pre_rs2: in_pre_rs2,
                     post_pc: in_post_pc,
                     post_rd: in_post_rd};
    end

    // Control and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            level_q       <= {LVL_W{1'b0}};
            order_q       <= {ORDER_W{1'b0}};
            drop_q        <= {DROP_W{1'b0}};
            gap_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            order_q       <= order_d;
            drop_q        <= drop_d;
            gap_pending_q <= gap_pending_d;
            overflow_q    <= overflow_d;
        end
    end

    // Record storage; written only on an accepted push so idle bus values never enter it.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wr_rec_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign head_s      = mem_q[rd_ptr_q];
    assign out_valid   = out_valid_s;
    assign out_order   = head_s.order;
    assign out_gap     = head_s.gap;
    assign out_rs1     = head_s.rs1;
    assign out_rs2     = head_s.rs2;
    assign out_rd      = head_s.rd;
    assign out_insn    = head_s.insn;
    assign out_pre_pc  = head_s.pre_pc;
    assign out_pre_rs1 = head_s.pre_rs1;
    assign out_pre_rs2 = head_s.pre_rs2;
    assign out_post_pc = head_s.post_pc;
    assign out_post_rd = head_s.post_rd;
    assign level       = level_q;
    assign drop_count  = drop_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/rvfi_trace_fifo.md
Name: rvfi_trace_fifo

Overview:
- Captures the RVFI retirement stream of picorv32 (one record per `rvfi_valid` cycle) and buffers it in a small FIFO.
- Presents records to a downstream consumer over a valid/ready handshake; consumers include the register/PC consistency checker and the trace dumper.
- RVFI has no backpressure, so the block never stalls the core: on overflow it drops records, counts them, and flags the gap.
- Each record is tagged with a monotonically increasing retirement order number.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- ORDER_W, 32, width of the retirement order counter.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  RVFI retirement strobe (`rvfi_valid`)
- in_rs1  input  5  rvfi_rs1
- in_rs2  input  5  rvfi_rs2
- in_rd  input  5  rvfi_rd
- in_insn  input  32  rvfi_insn
- in_pre_pc  input  32  rvfi_pre_pc
- in_pre_rs1  input  32  rvfi_pre_rs1
- in_pre_rs2  input  32  rvfi_pre_rs2
- in_post_pc  input  32  rvfi_post_pc
- in_post_rd  input  32  rvfi_post_rd
- out_valid  output  1  head record available
- out_ready  input  1  consumer accepts head this cycle
- out_order  output  ORDER_W  retirement index of head record
- out_gap  output  1  one or more records were dropped immediately before this one
- out_rs1, out_rs2, out_rd  output  5 each  head record fields
- out_insn, out_pre_pc, out_pre_rs1, out_pre_rs2, out_post_pc, out_post_rd  output  32 each  head record fields
- level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- drop_count  output  DROP_W  records dropped since reset; saturates at all-ones
- overflow  output  1  sticky; set on first drop, cleared only by reset

Behaviour:

Reset (asynchronous):
- Read/write pointers, level, order counter, drop_count, the internal `gap_pending` flag and overflow all go to 0.
- out_valid = 0.
- Stored contents are discarded. A reset mid-stream loses all buffered records; the first record after reset has order 0.

Handshake:
- pop = out_valid && out_ready.
- push_ok = in_valid && (level < DEPTH || pop). A full FIFO popping in the same cycle still accepts the incoming record.
- Push and pop in the same cycle leave level unchanged.

Latency:
- A record pushed at edge N appears at the head no earlier than after edge N. There is no same-cycle bypass: empty FIFO plus in_valid gives out_valid = 0 that cycle and 1 the next.

Output path:
- out_* fields are driven from the storage entry at the read pointer.
- out_valid = (level != 0).
- Output fields are stable while out_valid && !out_ready.

Order counter:
- Increments by 1 on every in_valid cycle, accepted or dropped, and wraps modulo 2^ORDER_W.
- The stored order is the counter value before the increment.

Drop (in_valid && !push_ok):
- Record is discarded.
- drop_count increments, saturating at 2^DROP_W - 1.
- overflow is set to 1.
- `gap_pending` is set to 1.

Gap flag:
- On push_ok, the stored gap bit equals the current `gap_pending`, and `gap_pending` is cleared the same edge.
- The consumer sees out_gap = 1 together with an order jump equal to the number of dropped records, modulo 2^ORDER_W.

Pointers:
- Widths are clog2(DEPTH); both wrap naturally.
- Full/empty is derived from level, not from pointer compare.

Other rules:
- in_* fields are sampled only when in_valid = 1; no X propagation into storage otherwise.
- out_ready while out_valid = 0 has no effect.

Test Plan:
1. Reset, then 3 consecutive in_valid records with in_pre_pc = 0, 4, 8 and out_ready = 1 -> out_valid rises one cycle after each push; out_order 0, 1, 2; out_pre_pc 0, 4, 8; out_gap = 0; level never exceeds 1.
2. out_ready = 0, DEPTH+2 = 10 pushes -> level = 8; drop_count = 2; overflow = 1. Then out_ready = 1 with 1 more push: records order 0..7 drain first, then order 10 arrives with out_gap = 1; out_gap = 0 on all earlier records.
3. FIFO full (level = 8), in_valid and out_ready high in the same cycle -> no drop; drop_count unchanged; level stays 8; head advances to order 1.
4. Fill to level 5, assert reset for one cycle between clock edges -> out_valid, level, drop_count and overflow are 0 immediately; next push carries order 0 with out_gap = 0.
5. out_ready = 0 for 4 cycles with head order 3 -> out_order and all out_* fields hold their values; level unchanged without pushes; pointers wrap correctly after 20 push/pop pairs.
6. drop_count preloaded near saturation by forcing 2^16 + 3 drops -> drop_count = 16'hFFFF and stays there; the order counter continues incrementing.
